// File: rtl/hls_deadlock_report_unit.sv
// Watches per-instance deadlock monitor flags, qualifies a sustained block on one
// tracked monitor, and issues a single backpressured report until software re-arms.
module hls_deadlock_report_unit #(
   parameter int NUM_MON = 4,
   parameter int IDX_W   = 2,
   parameter int THRESH  = 1024,
   parameter int CNT_W   = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_MON-1:0] mon_block,
   input  logic               clear,
   output logic               report_valid,
   input  logic               report_ready,
   output logic [IDX_W-1:0]   report_idx,
   output logic [NUM_MON-1:0] report_mask,
   output logic [CNT_W-1:0]   report_ts,
   output logic               deadlock,
   output logic [1:0]         state_dbg
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WATCH  = 2'd1;
   localparam logic [1:0] ST_REPORT = 2'd2;
   localparam logic [1:0] ST_HOLD   = 2'd3;

   localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(THRESH - 1);
   localparam logic [CNT_W-1:0] RUN_MAX  = CNT_W'(THRESH);
   localparam logic [CNT_W-1:0] TS_SAT   = {CNT_W{1'b1}};

   logic [1:0]         state_q,        state_d;
   logic [CNT_W-1:0]   ts_q,           ts_d;
   logic [CNT_W-1:0]   run_q,          run_d;
   logic [IDX_W-1:0]   idx_q,          idx_d;
   logic               report_valid_q, report_valid_d;
   logic [IDX_W-1:0]   report_idx_q,   report_idx_d;
   logic [NUM_MON-1:0] report_mask_q,  report_mask_d;
   logic [CNT_W-1:0]   report_ts_q,    report_ts_d;
   logic               deadlock_q,     deadlock_d;

   // Priority encoder: the lowest-numbered blocked monitor wins when several assert together.
   function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_MON-1:0] v);
      logic [IDX_W-1:0] r;
      r = {IDX_W{1'b0}};
      for (int i = NUM_MON - 1; i >= 0; i--) begin
         r = v[i] ? IDX_W'(i) : r;
      end
      return r;
   endfunction

   // Next-state and payload computation for the detection FSM.
   always_comb begin
      state_d        = state_q;
      run_d          = run_q;
      idx_d          = idx_q;
      report_valid_d = report_valid_q;
      report_idx_d   = report_idx_q;
      report_mask_d  = report_mask_q;
      report_ts_d    = report_ts_q;
      deadlock_d     = deadlock_q;
      ts_d           = (ts_q == TS_SAT) ? ts_q : ts_q + CNT_W'(1);

      case (state_q)
         ST_IDLE: begin
            if (|mon_block) begin
               state_d = ST_WATCH;
               idx_d   = lowest_set(mon_block);
               run_d   = CNT_W'(1);
            end else begin
               run_d   = {CNT_W{1'b0}};
            end
         end
         ST_WATCH: begin
            // A clear or a drop of the tracked bit abandons the run; other bits do not matter.
            if (clear || !mon_block[idx_q]) begin
               state_d = ST_IDLE;
               run_d   = {CNT_W{1'b0}};
            end else if (run_q == RUN_LAST) begin
               state_d        = ST_REPORT;
               run_d          = RUN_MAX;
               report_valid_d = 1'b1;
               deadlock_d     = 1'b1;
               report_idx_d   = idx_q;
               report_mask_d  = mon_block;
               report_ts_d    = ts_q;
            end else begin
               run_d = run_q + CNT_W'(1);
            end
         end
         ST_REPORT: begin
            if (report_ready) begin
               state_d        = ST_HOLD;
               report_valid_d = 1'b0;
            end else begin
               report_valid_d = 1'b1;
            end
         end
         ST_HOLD: begin
            if (clear) begin
               state_d    = ST_IDLE;
               deadlock_d = 1'b0;
               run_d      = {CNT_W{1'b0}};
            end else begin
               deadlock_d = 1'b1;
            end
         end
         default: begin
            state_d        = ST_IDLE;
            run_d          = {CNT_W{1'b0}};
            report_valid_d = 1'b0;
            deadlock_d     = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         ts_q           <= {CNT_W{1'b0}};
         run_q          <= {CNT_W{1'b0}};
         idx_q          <= {IDX_W{1'b0}};
         report_valid_q <= 1'b0;
         report_idx_q   <= {IDX_W{1'b0}};
         report_mask_q  <= {NUM_MON{1'b0}};
         report_ts_q    <= {CNT_W{1'b0}};
         deadlock_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         ts_q           <= ts_d;
         run_q          <= run_d;
         idx_q          <= idx_d;
         report_valid_q <= report_valid_d;
         report_idx_q   <= report_idx_d;
         report_mask_q  <= report_mask_d;
         report_ts_q    <= report_ts_d;
         deadlock_q     <= deadlock_d;
      end
   end

   assign report_valid = report_valid_q;
   assign report_idx   = report_idx_q;
   assign report_mask  = report_mask_q;
   assign report_ts    = report_ts_q;
   assign deadlock     = deadlock_q;
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_hls_deadlock_report_unit.sv
// Scoreboard bench for hls_deadlock_report_unit with NUM_MON=4, THRESH=8, CNT_W=16.
module tb_hls_deadlock_report_unit;

   typedef struct packed {
      logic [1:0]  idx;
      logic [3:0]  mask;
      logic [15:0] ts;
   } rep_t;

   logic        clock;
   logic        reset;
   logic [3:0]  mon_block;
   logic        clear;
   logic        report_valid;
   logic        report_ready;
   logic [1:0]  report_idx;
   logic [3:0]  report_mask;
   logic [15:0] report_ts;
   logic        deadlock;
   logic [1:0]  state_dbg;

   int   total;
   int   bad;
   int   ts_m;
   rep_t exp_q[$];

   hls_deadlock_report_unit #(
      .NUM_MON(4), .IDX_W(2), .THRESH(8), .CNT_W(16)
   ) dut (
      .clock(clock), .reset(reset), .mon_block(mon_block), .clear(clear),
      .report_valid(report_valid), .report_ready(report_ready),
      .report_idx(report_idx), .report_mask(report_mask), .report_ts(report_ts),
      .deadlock(deadlock), .state_dbg(state_dbg)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // One active edge; the timestamp model restarts on reset edges.
   task automatic step();
      @(posedge clock);
      if (reset) ts_m = 0;
      else if (ts_m != 65535) ts_m++;
      #1;
   endtask

   // From IDLE with mon_block held, 7 edges stay in WATCH, the 8th raises the report.
   task automatic detect(input logic [1:0] idx, input string tag);
      rep_t e;
      for (int i = 0; i < 7; i++) begin
         step();
         check({tag, "_watch_state"}, 32'(state_dbg), 32'd1);
         check({tag, "_watch_valid"}, 32'(report_valid), 32'd0);
      end
      e.idx  = idx;
      e.mask = mon_block;
      e.ts   = 16'(ts_m);
      exp_q.push_back(e);
      step();
      check({tag, "_rep_valid"}, 32'(report_valid), 32'd1);
      check({tag, "_rep_state"}, 32'(state_dbg), 32'd2);
      check({tag, "_rep_dl"}, 32'(deadlock), 32'd1);
   endtask

   // Accept the pending report, then re-arm with clear.
   task automatic accept_and_clear(input string tag);
      report_ready = 1'b1;
      step();
      report_ready = 1'b0;
      check({tag, "_hold_state"}, 32'(state_dbg), 32'd3);
      check({tag, "_hold_valid"}, 32'(report_valid), 32'd0);
      check({tag, "_hold_dl"}, 32'(deadlock), 32'd1);
      mon_block = 4'b0000;
      clear = 1'b1;
      step();
      clear = 1'b0;
      check({tag, "_clr_state"}, 32'(state_dbg), 32'd0);
      check({tag, "_clr_dl"}, 32'(deadlock), 32'd0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_state"}, 32'(state_dbg), 32'd0);
      check({tag, "_valid"}, 32'(report_valid), 32'd0);
      check({tag, "_dl"}, 32'(deadlock), 32'd0);
      check({tag, "_idx"}, 32'(report_idx), 32'd0);
      check({tag, "_mask"}, 32'(report_mask), 32'd0);
      check({tag, "_ts"}, 32'(report_ts), 32'd0);
   endtask

   // Monitor: every accepted report must match the oldest expected entry.
   always @(negedge clock) begin
      if (!reset && report_valid && report_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_report actual idx=%0d mask=%b ts=%0d required none",
                     report_idx, report_mask, report_ts);
         end else begin
            rep_t e;
            e = exp_q.pop_front();
            check("sb_idx", 32'(report_idx), 32'(e.idx));
            check("sb_mask", 32'(report_mask), 32'(e.mask));
            check("sb_ts", 32'(report_ts), 32'(e.ts));
         end
      end
   end

   initial begin
      total = 0;
      bad = 0;
      ts_m = 0;
      reset = 1'b1;
      mon_block = 4'b0000;
      clear = 1'b0;
      report_ready = 1'b0;
      step();
      step();
      check_reset_values("reset");

      // Qualifying block on bit 2, then backpressure and ignored clear in REPORT.
      reset = 1'b0;
      mon_block = 4'b0100;
      detect(2'd2, "q1");
      check("q1_ts_abs", 32'(report_ts), 32'd7);
      check("q1_idx_abs", 32'(report_idx), 32'd2);
      check("q1_mask_abs", 32'(report_mask), 32'b0100);
      for (int i = 0; i < 3; i++) begin
         mon_block = (i == 1) ? 4'b0000 : 4'b1011;
         clear = (i == 2);
         step();
         check("bp_valid", 32'(report_valid), 32'd1);
         check("bp_state", 32'(state_dbg), 32'd2);
         check("bp_idx", 32'(report_idx), 32'd2);
         check("bp_mask", 32'(report_mask), 32'b0100);
         check("bp_ts", 32'(report_ts), 32'd7);
      end
      clear = 1'b0;
      report_ready = 1'b1;
      step();
      report_ready = 1'b0;
      check("rdy_state", 32'(state_dbg), 32'd3);
      check("rdy_valid", 32'(report_valid), 32'd0);
      check("rdy_dl", 32'(deadlock), 32'd1);

      // Clear in HOLD with all bits high: IDLE first, then WATCH tracking bit 0.
      mon_block = 4'b1111;
      step();
      check("hold_ignore_mon", 32'(state_dbg), 32'd3);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("hclr_state", 32'(state_dbg), 32'd0);
      check("hclr_dl", 32'(deadlock), 32'd0);
      check("hclr_mask_kept", 32'(report_mask), 32'b0100);
      check("hclr_idx_kept", 32'(report_idx), 32'd2);
      detect(2'd0, "all");
      accept_and_clear("all");

      // Glitch: five high samples then low never reports.
      mon_block = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         step();
         check("gl_state", 32'(state_dbg), 32'd1);
         check("gl_valid", 32'(report_valid), 32'd0);
      end
      mon_block = 4'b0000;
      step();
      check("gl_idle", 32'(state_dbg), 32'd0);
      check("gl_valid_end", 32'(report_valid), 32'd0);

      // Simultaneous bits: lowest index is tracked, mask snapshots both.
      mon_block = 4'b1010;
      detect(2'd1, "sim");
      accept_and_clear("sim");

      // Tracked bit 1 drops while bit 3 stays: IDLE, then WATCH on bit 3.
      mon_block = 4'b1010;
      step();
      step();
      mon_block = 4'b1000;
      step();
      check("drop_idle", 32'(state_dbg), 32'd0);
      detect(2'd3, "drop");
      accept_and_clear("drop");

      // Clear in WATCH restarts the run from zero.
      mon_block = 4'b0100;
      for (int i = 0; i < 4; i++) step();
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("wclr_state", 32'(state_dbg), 32'd0);
      detect(2'd2, "wclr");
      accept_and_clear("wclr");

      // Reset at run count 5: a fresh 8-sample run is needed.
      mon_block = 4'b0010;
      for (int i = 0; i < 5; i++) step();
      reset = 1'b1;
      step();
      check_reset_values("rst_watch");
      reset = 1'b0;
      detect(2'd1, "rst1");
      check("rst1_ts_abs", 32'(report_ts), 32'd7);

      // Reset during REPORT drops the pending report.
      reset = 1'b1;
      clear = 1'b1;
      step();
      clear = 1'b0;
      check_reset_values("rst_rep");
      exp_q.delete();
      reset = 1'b0;
      detect(2'd1, "rst2");
      accept_and_clear("rst2");

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hls_deadlock_report_unit.md
HLS_DEADLOCK_REPORT_UNIT -- requirements
Module: hls_deadlock_report_unit

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- NUM_MON, 4, number of monitor block inputs
- IDX_W, 2, report index width, max(1, clog2(NUM_MON))
- THRESH, 1024, consecutive block cycles that qualify as deadlock (>=2)
- CNT_W, 16, run-counter and timestamp width (2^CNT_W-1 >= THRESH)

REQ-002 SHALL have ports (name, direction, width, meaning):
- clock, in, 1, rising-edge clock
- reset, in, 1, synchronous, active-high reset
- mon_block, in, NUM_MON, level block flags from the per-instance deadlock monitors
- clear, in, 1, single-cycle request to re-arm after a report
- report_valid, out, 1, report payload valid
- report_ready, in, 1, consumer accepts report
- report_idx, out, IDX_W, index of the tracked monitor
- report_mask, out, NUM_MON, snapshot of mon_block at detection
- report_ts, out, CNT_W, timestamp at detection
- deadlock, out, 1, sticky deadlock flag
- state_dbg, out, 2, current FSM state encoding

Function
REQ-003 SHALL implement an FSM with states IDLE=0, WATCH=1, REPORT=2, HOLD=3, exposed on state_dbg.
REQ-004 SHALL keep a free-running timestamp counter ts that increments every cycle and saturates at all-ones.
REQ-005 SHALL transition IDLE->WATCH when any mon_block bit is sampled high:
- latch the lowest set index into the tracked index
- load run counter = 1
REQ-006 In WATCH, SHALL increment the run counter on each edge at which mon_block[tracked] is sampled high.
REQ-007 In WATCH, SHALL return to IDLE with run counter = 0 on the first edge at which mon_block[tracked] is sampled low, regardless of other bits.
REQ-008 In WATCH, SHALL transition to REPORT on the edge at which the run counter would reach THRESH; registered on that same edge:
- report_valid=1, deadlock=1
- report_idx = tracked index
- report_mask = sampled mon_block
- report_ts = ts
REQ-009 In REPORT, SHALL hold report_valid and all payload outputs stable until report_ready is sampled high, then go to HOLD with report_valid=0 on that edge.
REQ-010 SHALL ignore mon_block changes in REPORT and HOLD.
REQ-011 SHALL keep deadlock at 1 in REPORT and HOLD; it clears only via clear in HOLD or via reset.
REQ-012 clear sampled in HOLD SHALL produce next state IDLE, deadlock=0, run counter=0; payload outputs retain their last values.
REQ-013 clear sampled in WATCH SHALL produce IDLE with run counter=0.
REQ-014 clear sampled in IDLE or REPORT SHALL be ignored (no report is ever dropped).
REQ-015 When entering IDLE on a clear, SHALL not evaluate mon_block on that edge; re-arm evaluation starts on the next edge.
REQ-016 report_valid SHALL not depend combinationally on report_ready.
REQ-017 The run counter SHALL never exceed THRESH.

Reset
REQ-018 On reset sampled high, the block SHALL force, on that edge:
- state=IDLE
- report_valid=0, deadlock=0
- report_idx=0, report_mask=0, report_ts=0
- run counter=0, ts=0
REQ-019 Reset SHALL take priority over clear, report_ready and mon_block in every state, including mid-WATCH and mid-REPORT.

Verification (NUM_MON=4, THRESH=8, CNT_W=16)
REQ-020 Qualifying block: mon_block=0100 from edge 1 onward -> state WATCH after edge 1; after edge 8: report_valid=1, deadlock=1, idx=2, mask=0100, report_ts=7.
REQ-021 Glitch rejection: mon_block=0001 for 5 cycles, then 0000 -> return to IDLE after edge 6, report_valid stays 0 throughout.
REQ-022 Simultaneous and other-bit drop:
- mon_block=1010 held -> idx=1, mask=1010
- separately, tracked bit 1 drops while bit 3 stays high -> IDLE, then WATCH with idx=3 on the next edge
REQ-023 Backpressure: report_ready low for 3 cycles after report -> payload unchanged for 3 cycles; on the ready edge -> HOLD, report_valid=0, deadlock=1.
REQ-024 Clear handling:
- clear pulsed in REPORT -> ignored
- clear pulsed in HOLD with mon_block=1111 -> IDLE, deadlock=0; WATCH with idx=0 one edge later
REQ-025 Reset mid-operation: reset asserted at run count 5 or during REPORT -> all outputs at reset values after that edge; no report issued until 8 new consecutive high samples.
